// File: rtl/dct4_row_gather.sv
// -----------------------------------------------------------------------------
// dct4_row_gather
//   Upstream stage of the 4-point CMVM DCT. Packs each group of four serial
//   samples into one row and presents it in parallel on dct_in_0..3. Two row
//   banks work ping-pong so one row can be held for the consumer while the next
//   one fills, sustaining one sample per clock.
//
//   Optional build macro: DCT4_ROW_GATHER_LEVEL_SHIFT_EN
//     When defined, s_data[7:0] is an unsigned pixel and the stored sample is
//     pixel-128 sign-extended to IN_W (s_data[IN_W-1:8] ignored, IN_W >= 9).
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     input sample handshake
//   s_data [IN_W]       input sample (signed)
//   s_last              final sample of a row
//   m_valid/m_ready     row handshake toward dct4_cmvm
//   dct_in_0..3 [IN_W]  row samples, lane 0 = first beat
//   err_frame           sticky framing error
//   row_count [16]      rows delivered, wraps
// -----------------------------------------------------------------------------

// One row lane: holds this lane's sample for both banks plus the output
// register that feeds dct_in_k. The output register is loaded only when a new
// row becomes visible, so the lane holds the last delivered value otherwise.
module dct4_row_gather_lane #(
   parameter int IN_W = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic            wr_bank,
   input  logic [IN_W-1:0] wr_data,
   input  logic            ld_en,
   input  logic            ld_bank,
   output logic [IN_W-1:0] q
);

   logic [1:0][IN_W-1:0] bank;
   logic                 bypass;

   // The row being loaded may be completing on this very edge; the lane
   // written this cycle must come straight from the input.
   assign bypass = wr_en && (wr_bank == ld_bank);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank <= '0;
         q    <= '0;
      end else begin
         if (wr_en) bank[wr_bank] <= wr_data;
         if (ld_en) q <= bypass ? wr_data : bank[ld_bank];
      end
   end

endmodule

module dct4_row_gather #(
   parameter int IN_W = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            s_valid,
   output logic            s_ready,
   input  logic [IN_W-1:0] s_data,
   input  logic            s_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [IN_W-1:0] dct_in_0,
   output logic [IN_W-1:0] dct_in_1,
   output logic [IN_W-1:0] dct_in_2,
   output logic [IN_W-1:0] dct_in_3,
   output logic            err_frame,
   output logic [15:0]     row_count
);

   localparam int LANES = 4;

   logic [1:0]                  bank_vld;
   logic                        wr_ptr;
   logic                        rd_ptr;
   logic [1:0]                  idx;
   logic [IN_W-1:0]             wr_data;
   logic [LANES-1:0][IN_W-1:0]  lane_q;

   logic in_fire, out_fire, last_lane, row_done, drop_row, frame_bad;
   logic other_vld, ld_en, ld_bank;

   // Input side only looks at bank occupancy, never at s_valid.
   assign s_ready   = rst_n & ~(&bank_vld);
   assign m_valid   = bank_vld[rd_ptr];

   assign in_fire   = s_valid & s_ready;
   assign out_fire  = m_valid & m_ready;
   assign last_lane = (idx == 2'd3);
   assign row_done  = in_fire & last_lane;
   assign drop_row  = in_fire & s_last & ~last_lane;
   assign frame_bad = in_fire & (s_last != last_lane);
   assign other_vld = bank_vld[~rd_ptr];

   // Output register load: either the queued bank slides in after a transfer,
   // or a row completing right now becomes the visible one (nothing visible,
   // or the visible row is leaving this cycle). With a row queued the input
   // is stalled, so the two cases never coincide.
   assign ld_en   = (out_fire & other_vld) | (row_done & (out_fire | ~m_valid));
   assign ld_bank = (out_fire & other_vld) ? ~rd_ptr : wr_ptr;

`ifdef DCT4_ROW_GATHER_LEVEL_SHIFT_EN
   // pixel-128 equals the pixel with its MSB inverted read as signed 8-bit.
   logic unused_hi;
   assign unused_hi = ^s_data[IN_W-1:8];
   assign wr_data   = {{(IN_W-7){~s_data[7]}}, s_data[6:0]};
`else
   assign wr_data   = s_data;
`endif

   genvar k;
   generate
      for (k = 0; k < LANES; k++) begin : g_lane
         dct4_row_gather_lane #(.IN_W(IN_W)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (in_fire && (idx == 2'(k))),
            .wr_bank (wr_ptr),
            .wr_data (wr_data),
            .ld_en   (ld_en),
            .ld_bank (ld_bank),
            .q       (lane_q[k])
         );
      end
   endgenerate

   assign dct_in_0 = lane_q[0];
   assign dct_in_1 = lane_q[1];
   assign dct_in_2 = lane_q[2];
   assign dct_in_3 = lane_q[3];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bank_vld  <= '0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         idx       <= '0;
         err_frame <= 1'b0;
         row_count <= '0;
      end else begin
         // With one bank valid the write bank is the other one, so a transfer
         // and a completion in the same cycle touch different banks.
         if (out_fire) begin
            bank_vld[rd_ptr] <= 1'b0;
            rd_ptr           <= ~rd_ptr;
            row_count        <= row_count + 16'd1;
         end
         if (row_done) begin
            bank_vld[wr_ptr] <= 1'b1;
            wr_ptr           <= ~wr_ptr;
         end
         if (in_fire) idx <= (last_lane || drop_row) ? 2'd0 : idx + 2'd1;
         if (frame_bad) err_frame <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dct4_row_gather.sv
module tb_dct4_row_gather;
   localparam int W = 10;
   typedef logic [3:0][W-1:0] row_t;
   typedef struct { row_t d; row_t e; } vec_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
   logic [W-1:0] s_data = '0;
   logic s_ready, m_valid, err_frame;
   logic [W-1:0] dct_in_0, dct_in_1, dct_in_2, dct_in_3;
   logic [15:0] row_count;

   int nvec = 0, nmis = 0;
   row_t exp_q[$];
   vec_t tbl[8];

   always #5 clk = ~clk;

   dct4_row_gather #(.IN_W(W)) dut (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
      .dct_in_0(dct_in_0), .dct_in_1(dct_in_1), .dct_in_2(dct_in_2),
      .dct_in_3(dct_in_3), .err_frame(err_frame), .row_count(row_count));

   function automatic logic [W-1:0] xf(input logic [W-1:0] d);
`ifdef DCT4_ROW_GATHER_LEVEL_SHIFT_EN
      logic signed [W-1:0] t;
      t = $signed({2'b00, d[7:0]}) - 10'sd128;
      return t;
`else
      return d;
`endif
   endfunction

   function automatic row_t xrow(input row_t r);
      row_t o;
      for (int i = 0; i < 4; i++) o[i] = xf(r[i]);
      return o;
   endfunction

   function automatic row_t outs();
      return {dct_in_3, dct_in_2, dct_in_1, dct_in_0};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: every accepted output row must match the next expected row.
   always @(negedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         if (exp_q.size() == 0) chk("unexpected_row", 64'(outs()), 64'hDEAD);
         else chk("row_data", 64'(outs()), 64'(exp_q.pop_front()));
      end
   end

   // Drive one beat from posedge+1; returns at posedge+1 after acceptance.
   task automatic send_beat(input logic [W-1:0] d, input logic l);
      s_valid = 1'b1; s_data = d; s_last = l;
      for (int t = 0; t < 50 && !s_ready; t++) @(negedge clk);
      if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'd1);
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic send_row(input row_t r, input logic last3);
      exp_q.push_back(xrow(r));
      for (int i = 0; i < 4; i++) send_beat(r[i], (i == 3) ? last3 : 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; #1;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_m_valid", 64'(m_valid), 64'd0);
      exp_q.delete();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   int rc0;
   bit low_seen, done;

   initial begin
      for (int i = 0; i < 8; i++) begin
         tbl[i].d = {W'(4*i+13), W'(4*i+12), W'(4*i+11), W'(4*i+10)};
         if (i == 3) tbl[i].d = {W'(-5), W'(100), W'(-200), W'(0)};
         if (i == 6) tbl[i].d = {W'(511), W'(-512), W'(1), W'(-1)};
         tbl[i].e = xrow(tbl[i].d);
      end

      // Reset state
      #2; do_reset();
      chk("post_rst_s_ready", 64'(s_ready), 64'd1);
      chk("post_rst_m_valid", 64'(m_valid), 64'd0);
      chk("post_rst_dct_in", 64'(outs()), 64'd0);
      chk("post_rst_err", 64'(err_frame), 64'd0);
      chk("post_rst_count", 64'(row_count), 64'd0);

      // Basic row, latency of one clock after 4th beat
      m_ready = 1'b1;
      exp_q.push_back(xrow({W'(4), W'(3), W'(2), W'(1)}));
      send_beat(W'(1), 0); send_beat(W'(2), 0); send_beat(W'(3), 0);
      chk("no_valid_before_4th", 64'(m_valid), 64'd0);
      send_beat(W'(4), 1);
      chk("valid_after_4th", 64'(m_valid), 64'd1);
      chk("row1_data", 64'(outs()), 64'(xrow({W'(4), W'(3), W'(2), W'(1)})));
      @(posedge clk); #1;
      chk("row1_count", 64'(row_count), 64'd1);
      chk("row1_err", 64'(err_frame), 64'd0);
      chk("row1_drained", 64'(m_valid), 64'd0);

      // Back-pressure: hold a row, fill the second bank, stall input
      m_ready = 1'b0;
      send_row({W'(-1), W'(-1), W'(-1), W'(-1)}, 1'b1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("hold_row", {63'd0, m_valid} << 40 | 64'(outs()),
             (64'd1 << 40) | 64'(xrow({W'(-1), W'(-1), W'(-1), W'(-1)})));
      end
      @(posedge clk); #1;
      chk("ready_one_full", 64'(s_ready), 64'd1);
      send_row({W'(14), W'(13), W'(12), W'(11)}, 1'b1);
      chk("ready_both_full", 64'(s_ready), 64'd0);
      s_valid = 1'b1; s_data = W'(99); s_last = 1'b1;
      repeat (2) @(posedge clk);
      #1 s_valid = 1'b0; s_last = 1'b0;
      chk("full_beats_ignored", 64'(err_frame), 64'd0);
      m_ready = 1'b1;
      @(negedge clk);
      chk("b2b_first", 64'(outs()), 64'(xrow({W'(-1), W'(-1), W'(-1), W'(-1)})));
      @(negedge clk);
      chk("b2b_second_valid", 64'(m_valid), 64'd1);
      chk("b2b_second", 64'(outs()), 64'(xrow({W'(14), W'(13), W'(12), W'(11)})));
      @(negedge clk);
      chk("b2b_drained", 64'(m_valid), 64'd0);
      chk("b2b_count", 64'(row_count), 64'd3);
      @(posedge clk); #1;

      // Continuous stream of 8 table rows
      rc0 = row_count; low_seen = 0; done = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               exp_q.push_back(tbl[i].e);
               for (int b = 0; b < 4; b++) send_beat(tbl[i].d[b], b == 3);
            end
            done = 1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (!s_ready) low_seen = 1;
            end
         end
      join
      repeat (3) @(posedge clk); #1;
      chk("stream_ready_never_low", 64'(low_seen), 64'd0);
      chk("stream_count", 64'(row_count), 64'(16'(rc0 + 8)));

      // Early s_last: partial row dropped
      rc0 = row_count;
      send_beat(W'(5), 0); send_beat(W'(6), 1);
      chk("early_last_err", 64'(err_frame), 64'd1);
      chk("early_last_no_row", 64'(m_valid), 64'd0);
      send_row({W'(10), W'(9), W'(8), W'(7)}, 1'b1);
      repeat (2) @(posedge clk); #1;
      chk("early_last_count", 64'(row_count), 64'(16'(rc0 + 1)));

      // Missing s_last on 4th beat: row kept, error flagged
      do_reset();
      chk("err_cleared", 64'(err_frame), 64'd0);
      send_row({W'(40), W'(30), W'(20), W'(10)}, 1'b0);
      chk("missing_last_err", 64'(err_frame), 64'd1);
      @(posedge clk); #1;
      chk("missing_last_count", 64'(row_count), 64'd1);

      // Reset mid-row, then a clean row
      do_reset();
      send_beat(W'(77), 0); send_beat(W'(78), 0);
      @(negedge clk); do_reset();
      send_row({W'(4), W'(3), W'(2), W'(1)}, 1'b1);
      @(posedge clk); #1;
      chk("after_midrow_rst_count", 64'(row_count), 64'd1);

      // Reset with a row pending on the output
      m_ready = 1'b0;
      exp_q.delete();
      send_row({W'(8), W'(7), W'(6), W'(5)}, 1'b1);
      chk("pending_valid", 64'(m_valid), 64'd1);
      #2 do_reset();
      chk("pending_rst_dct_in", 64'(outs()), 64'd0);
      m_ready = 1'b1;
      send_row({W'(4), W'(3), W'(2), W'(1)}, 1'b1);
      @(posedge clk); #1;
      chk("after_pending_rst_count", 64'(row_count), 64'd1);

`ifdef DCT4_ROW_GATHER_LEVEL_SHIFT_EN
      m_ready = 1'b0;
      exp_q.delete();
      send_beat(W'(0), 0); send_beat(W'(128), 0); send_beat(W'(255), 0); send_beat(W'(129), 1);
      chk("lshift", 64'(outs()), 64'({W'(1), W'(127), W'(0), W'(-128)}));
      exp_q.push_back({W'(1), W'(127), W'(0), W'(-128)});
      m_ready = 1'b1;
      @(posedge clk); #1;
`endif

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
